// File: rtl/arbiter_rr.sv
// Registered round-robin arbiter: one-hot grant with encoded index, rotating
// priority, and an optional bounded hold time that preempts a busy owner.
module arbiter_rr #(
  parameter int N       = 8,
  parameter int MAXHOLD = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int IW = $clog2(N);
  localparam int CW = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAXHOLD);
  localparam logic [CW-1:0] CNT_LAST = (MAXHOLD > 0) ? CW'(MAXHOLD - 1) : '0;
  localparam bit            HOLD_LIMITED = (MAXHOLD > 0);
  localparam logic [IW-1:0] LAST_ID  = IW'(N - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic [N-1:0]  cand;
  logic [IW:0]   scan;
  logic          sel_found;
  logic [IW-1:0] sel_id;
  logic [IW-1:0] sel_next;
  logic          owner_req;
  logic          at_limit;
  logic          take;
  logic          drop;

  // Masking with the current grant excludes the owner; in IDLE grant is zero.
  always_comb begin
    cand      = req & ~grant;
    scan      = '0;
    sel_found = 1'b0;
    sel_id    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      scan = {1'b0, ptr} + (IW+1)'(i);
      if (scan >= (IW+1)'(N)) begin
        scan = scan - (IW+1)'(N);
      end
      if (!sel_found && cand[scan[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_next  = (sel_id == LAST_ID) ? '0 : sel_id + IW'(1);
    owner_req = |(req & grant);
    // cnt saturates at MAXHOLD, so "cnt >= MAXHOLD-1" is one of two values.
    at_limit  = HOLD_LIMITED && ((cnt == CNT_LAST) || (cnt == CNT_MAX));
    take      = sel_found && (!owner_req || at_limit);
    drop      = (state == GRANT) && !owner_req && !sel_found;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else if (take) begin
      state       <= GRANT;
      ptr         <= sel_next;
      cnt         <= '0;
      grant       <= N'(1) << sel_id;
      grant_valid <= 1'b1;
      grant_id    <= sel_id;
    end else if (drop) begin
      state       <= IDLE;
      cnt         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else if ((state == GRANT) && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_arbiter_rr.sv
// Directed bench for arbiter_rr: N=4 with MAXHOLD of 4, 0 (unlimited) and 1.
module tb_arbiter_rr;

  logic       clk = 1'b0;
  logic       nreset;
  logic [3:0] req_a, req_b;
  logic [3:0] ga, gb, gc;
  logic       va, vb, vc;
  logic [1:0] ida, idb, idc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arbiter_rr #(.N(4), .MAXHOLD(4)) u_hold4 (
    .clk(clk), .nreset(nreset), .req(req_a),
    .grant(ga), .grant_valid(va), .grant_id(ida)
  );

  arbiter_rr #(.N(4), .MAXHOLD(0)) u_hold0 (
    .clk(clk), .nreset(nreset), .req(req_b),
    .grant(gb), .grant_valid(vb), .grant_id(idb)
  );

  arbiter_rr #(.N(4), .MAXHOLD(1)) u_hold1 (
    .clk(clk), .nreset(nreset), .req(req_b),
    .grant(gc), .grant_valid(vc), .grant_id(idc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    nreset = 1'b0;
    req_a  = 4'b1111;
    req_b  = 4'b0000;

    // Reset with requests pending
    repeat (3) step();
    chk("rst_grant", 32'(ga), 0);
    chk("rst_valid", 32'(va), 0);
    chk("rst_id", 32'(ida), 0);
    chk("rst_grant_b", 32'(gb), 0);
    chk("rst_grant_c", 32'(gc), 0);

    // All requesting: 4-cycle tenures in index order
    nreset = 1'b1;
    step();
    for (int k = 0; k < 20; k++) begin
      if (k > 0) step();
      e = (k / 4) % 4;
      chk("rot_id", 32'(ida), e);
      chk("rot_grant", 32'(ga), 1 << e);
      chk("rot_valid", 32'(va), 1);
    end

    // Asynchronous reset mid-grant
    #1 nreset = 1'b0;
    #1;
    chk("async_grant", 32'(ga), 0);
    chk("async_valid", 32'(va), 0);
    chk("async_id", 32'(ida), 0);
    step();

    // Single request latency and release
    req_a  = 4'b0100;
    nreset = 1'b1;
    step();
    chk("lat_grant", 32'(ga), 32'h4);
    chk("lat_id", 32'(ida), 2);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("lat_hold", 32'(ga), 32'h4);
    end
    req_a = 4'b0000;
    step();
    chk("rel_grant", 32'(ga), 0);
    chk("rel_valid", 32'(va), 0);
    chk("rel_id", 32'(ida), 0);

    // Back-to-back handover without an idle cycle
    nreset = 1'b0;
    step();
    req_a  = 4'b1010;
    nreset = 1'b1;
    step();
    chk("b2b_first", 32'(ga), 32'h2);
    step();
    chk("b2b_hold", 32'(ga), 32'h2);
    req_a = 4'b1000;
    step();
    chk("b2b_move", 32'(ga), 32'h8);
    chk("b2b_valid", 32'(va), 1);
    chk("b2b_id", 32'(ida), 3);
    req_a = 4'b0111;
    step();
    chk("b2b_ptr_wrap", 32'(ga), 32'h1);

    // Sole requester holds past MAXHOLD, then is preempted
    nreset = 1'b0;
    step();
    req_a  = 4'b0001;
    nreset = 1'b1;
    step();
    chk("sole_first", 32'(ga), 32'h1);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("sole_hold", 32'(ga), 32'h1);
    end
    req_a = 4'b1001;
    step();
    chk("sole_preempt", 32'(ga), 32'h8);
    chk("sole_preempt_id", 32'(ida), 3);

    // Unlimited hold (MAXHOLD=0) and per-cycle rotation (MAXHOLD=1)
    req_b = 4'b0011;
    step();
    for (int k = 0; k < 50; k++) begin
      if (k > 0) step();
      chk("unl_hold", 32'(gb), 32'h1);
      if (k < 6) begin
        chk("mh1_grant", 32'(gc), 1 << (k % 2));
        chk("mh1_valid", 32'(vc), 1);
      end
    end
    req_b = 4'b0010;
    step();
    chk("unl_move", 32'(gb), 32'h2);
    chk("unl_move_id", 32'(idb), 1);
    chk("mh1_single", 32'(gc), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbiter_rr.md
Name: arbiter_rr

Overview:
- Registered round-robin arbiter that shares a single resource among N requesters with fair rotation.
- The granted requester keeps ownership while its request stays high, up to a bounded hold time.
- Sits in front of any shared datapath (bus, memory port, FIFO write side) where fixed priority would starve low-priority requesters.
- Grant is one-hot; an encoded index and a valid flag are also provided.

Parameters:
- N, 8, number of requesters; legal range N >= 2.
- MAXHOLD, 16, maximum consecutive grant cycles while another request is pending. 0 = unlimited hold, no preemption.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- nreset  input  1  asynchronous, active-low reset.
- req  input  N  request vector; req[i] high = requester i wants or holds the resource.
- grant  output  N  registered one-hot grant vector; all zeros when idle.
- grant_valid  output  1  registered; high when grant is non-zero.
- grant_id  output  $clog2(N)  registered index of the granted requester; 0 when grant_valid is low.

Behaviour:
- Reset (nreset low, asynchronous):
  - grant = 0, grant_valid = 0, grant_id = 0.
  - pointer ptr = 0, hold counter cnt = 0, state = IDLE.
  - Deassertion of reset is used synchronously.
  - Reset during a grant drops the grant immediately; no completion.
- Internal state:
  - ptr: $clog2(N) bits, the highest-priority index for the next selection.
  - cnt: $clog2(MAXHOLD+1) bits, counts cycles in the current grant.
  - state: IDLE or GRANT.
- Selection function: the first i with req[i] high, searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (modulo N).
- IDLE:
  - grant = 0.
  - If any req bit is high, the next edge grants the selected index k: grant = 1<<k, grant_id = k, grant_valid = 1, cnt = 0, ptr = (k+1) mod N, state = GRANT.
  - Latency from req rising to grant: exactly 1 cycle.
- GRANT with owner g:
  - Release:
    - If req[g] is low at an edge, select among the current req excluding g.
    - If a winner k exists, grant moves directly to k at that edge, with no idle bubble; cnt = 0, ptr = (k+1) mod N.
    - Otherwise grant = 0 and state = IDLE.
  - Hold: if req[g] is high and no preemption applies, grant is unchanged and cnt increments, saturating at MAXHOLD.
  - Preemption:
    - Applies when MAXHOLD != 0, cnt == MAXHOLD-1, req[g] is high, and another req bit is high.
    - Grant moves to the selected winner among the requests excluding g; cnt = 0, ptr updated as above.
    - The preempted requester keeps its req high and re-competes normally.
  - Sole requester: if req[g] is high and there is no other request, the grant is held indefinitely and cnt saturates.
    - A request from another requester arriving after cnt >= MAXHOLD-1 causes preemption at the next edge.
- Result: each owner holds for at most MAXHOLD cycles under contention.
- MAXHOLD = 1: grant rotates every cycle under contention.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == |grant.
  - grant_id matches grant.
  - Grant changes owner only at a clock edge.
  - A granted index always had req high in the cycle before it was granted.
- Fairness: with all N requests continuously high, each requester receives exactly one MAXHOLD-cycle tenure in every N*MAXHOLD-cycle window, in index order.
- No combinational path from req to any output.

Test Plan:
- Reset and idle: hold nreset low 3 cycles with req = 4'b1111 (N=4, MAXHOLD=4) -> grant = 0, grant_valid = 0, grant_id = 0. Assert nreset low mid-grant -> outputs clear within the same cycle, with no clock edge needed.
- Single request latency: N=4, raise req = 4'b0100 at cycle 0 -> grant = 4'b0100, grant_id = 2 at cycle 1. Drop req at cycle 5 -> grant = 0 at cycle 6.
- Rotation and preemption: N=4, MAXHOLD=4, req = 4'b1111 held continuously from reset -> grant_id sequence 0,1,2,3,0,..., each owner for exactly 4 cycles, no idle cycles.
- Back-to-back release: owner 1 with req = 4'b1010; drop req[1] after 2 cycles -> grant moves to 4'b1000 on the next edge, grant_valid never low; ptr is then 0.
- Sole requester hold: N=4, MAXHOLD=4, only req[0] high for 20 cycles -> grant = 4'b0001 throughout. Raise req[3] at cycle 20 -> grant = 4'b1000 at cycle 21.
- Unlimited hold: MAXHOLD=0, req = 4'b0011 for 50 cycles -> grant stays 4'b0001. Drop req[0] -> grant = 4'b0010 on the next edge.
